// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bus-side write port, status and transmitter handshake of uart_tx_fifo
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic             flush_i;
  logic             wr_en_i;
  logic [7:0]       wr_data_i;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
  logic             busy_o;
  logic             tx_start_o;
  logic [7:0]       tx_data_o;
  logic             tx_active_i;
  logic             tx_complete_i;
  modport slave (
    input  flush_i, wr_en_i, wr_data_i, tx_active_i, tx_complete_i,
    output full_o, empty_o, count_o, overflow_o, busy_o, tx_start_o, tx_data_o
  );
  modport master (
    output flush_i, wr_en_i, wr_data_i, tx_active_i, tx_complete_i,
    input  full_o, empty_o, count_o, overflow_o, busy_o, tx_start_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus sequencer issuing one transmitter start per queued byte
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input logic           clock_i,
  input logic           reset_n_i,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE} state_t;
  state_t           state, state_n;
  logic [7:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [CNT_W-1:0] cnt_n;
  logic             acc, pop;
  assign acc = bus.wr_en_i && !bus.full_o && !bus.flush_i;
  assign pop = (state == IDLE) && !bus.empty_o && !bus.flush_i;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = pop ? ISSUE : IDLE;
      ISSUE:     state_n = WAIT_ACT;
      WAIT_ACT:  state_n = bus.tx_active_i ? WAIT_DONE : bus.tx_complete_i ? IDLE : WAIT_ACT;
      WAIT_DONE: state_n = bus.tx_complete_i ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
    cnt_n = bus.flush_i ? '0 : bus.count_o + CNT_W'(acc) - CNT_W'(pop);
  end
  always_ff @(posedge clock_i)
    if (acc) mem[wp] <= bus.wr_data_i;
  // status flags are registered from next-state values so every output is a flop
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      wp             <= '0;
      rp             <= '0;
      bus.count_o    <= '0;
      bus.full_o     <= 1'b0;
      bus.empty_o    <= 1'b1;
      bus.overflow_o <= 1'b0;
      bus.busy_o     <= 1'b0;
      bus.tx_start_o <= 1'b0;
      bus.tx_data_o  <= '0;
    end else begin
      state          <= state_n;
      wp             <= bus.flush_i ? '0 : wp + ADDR_W'(acc);
      rp             <= bus.flush_i ? '0 : rp + ADDR_W'(pop);
      bus.count_o    <= cnt_n;
      bus.full_o     <= cnt_n == CNT_W'(DEPTH);
      bus.empty_o    <= cnt_n == '0;
      bus.overflow_o <= bus.flush_i ? 1'b0 : bus.overflow_o | (bus.wr_en_i & bus.full_o);
      bus.busy_o     <= (state_n != IDLE) || (cnt_n != '0);
      bus.tx_start_o <= state_n == ISSUE;
      bus.tx_data_o  <= pop ? mem[rp] : bus.tx_data_o;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenario tasks against a simple transmitter model
module tb_uart_tx_fifo;
  logic clk = 0, rst_n = 0;
  logic auto_tx = 1, man_active = 0, man_complete = 0;
  logic m_active = 0, m_complete = 0;
  logic [2:0] m_cnt = 0;
  int tot = 0, pas = 0;
  int n_start = 0, viol = 0, cyc = 0, last_cmp = -100, n_cmp = 0;
  logic prev_start = 0, outstanding = 0;
  logic [7:0] sq [$];
  uart_tx_fifo_if #(.DEPTH(16)) bus();
  uart_tx_fifo #(.DEPTH(16)) dut (.clock_i(clk), .reset_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.tx_active_i   = auto_tx ? m_active : man_active;
  assign bus.tx_complete_i = auto_tx ? m_complete : man_complete;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_complete <= 0; m_cnt <= 0;
    end else begin
      m_complete <= 0;
      if (bus.tx_start_o) begin
        m_active <= 1; m_cnt <= 3;
      end else if (m_active) begin
        if (m_cnt == 0) begin m_active <= 0; m_complete <= 1; end
        else m_cnt <= m_cnt - 1;
      end
    end
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      outstanding = 0; prev_start = 0;
    end else begin
      cyc++;
      if (bus.tx_start_o) begin
        n_start++;
        sq.push_back(bus.tx_data_o);
        if (prev_start || bus.tx_active_i || (auto_tx && (outstanding || cyc - last_cmp < 2))) viol++;
        outstanding = 1;
      end
      if (bus.tx_complete_i) begin outstanding = 0; last_cmp = cyc; n_cmp++; end
      prev_start = bus.tx_start_o;
    end
  end

  task automatic test_reset;
    bus.flush_i = 0; bus.wr_en_i = 0; bus.wr_data_i = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    tot++; if (bus.count_o !== 0) $display("FAIL reset_count got %0d want 0", bus.count_o); else pas++;
    tot++; if (bus.empty_o !== 1) $display("FAIL reset_empty got %b want 1", bus.empty_o); else pas++;
    tot++; if (bus.full_o !== 0 || bus.overflow_o !== 0 || bus.busy_o !== 0)
      $display("FAIL reset_flags got full=%b ovf=%b busy=%b want 0 0 0", bus.full_o, bus.overflow_o, bus.busy_o); else pas++;
    tot++; if (bus.tx_start_o !== 0 || bus.tx_data_o !== 0)
      $display("FAIL reset_tx got start=%b data=%h want 0 00", bus.tx_start_o, bus.tx_data_o); else pas++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int c0;
    bit seen = 0;
    c0 = n_cmp;
    bus.wr_en_i = 1; bus.wr_data_i = 8'h55;
    @(negedge clk);
    bus.wr_en_i = 0;
    tot++; if (bus.count_o !== 1 || bus.busy_o !== 1)
      $display("FAIL single_queued got count=%0d busy=%b want 1 1", bus.count_o, bus.busy_o); else pas++;
    for (int i = 0; i < 3 && !seen; i++) begin
      if (bus.tx_start_o) seen = 1; else @(negedge clk);
    end
    tot++; if (!seen) $display("FAIL single_start got no pulse want pulse within 3 cycles"); else pas++;
    tot++; if (bus.tx_data_o !== 8'h55 || bus.count_o !== 0)
      $display("FAIL single_data got data=%h count=%0d want 55 0", bus.tx_data_o, bus.count_o); else pas++;
    for (int i = 0; i < 20 && bus.busy_o; i++) @(negedge clk);
    tot++; if (bus.busy_o !== 0 || n_cmp == c0)
      $display("FAIL single_busy got busy=%b completes=%0d want 0 after complete", bus.busy_o, n_cmp - c0); else pas++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = viol;
    sq.delete();
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en_i = 1; bus.wr_data_i = 8'(i);
      @(negedge clk);
    end
    bus.wr_en_i = 0;
    for (int i = 0; i < 200 && !(sq.size() == 4 && !bus.busy_o); i++) @(negedge clk);
    tot++; if (sq.size() != 4) $display("FAIL b2b_count got %0d starts want 4", sq.size()); else pas++;
    for (int i = 0; i < 4 && i < sq.size(); i++) begin
      tot++; if (sq[i] !== 8'(i + 1)) $display("FAIL b2b_order[%0d] got %h want %h", i, sq[i], 8'(i + 1)); else pas++;
    end
    tot++; if (viol != v0) $display("FAIL b2b_handshake got %0d violations want 0", viol - v0); else pas++;
  endtask

  task automatic test_overflow;
    auto_tx = 0; man_active = 1;
    for (int i = 0; i < 17; i++) begin
      bus.wr_en_i = 1; bus.wr_data_i = 8'h10 + 8'(i);
      @(negedge clk);
    end
    tot++; if (bus.count_o !== 16 || bus.full_o !== 1 || bus.overflow_o !== 0)
      $display("FAIL ovf_fill got count=%0d full=%b ovf=%b want 16 1 0", bus.count_o, bus.full_o, bus.overflow_o); else pas++;
    bus.wr_data_i = 8'h99;
    @(negedge clk);
    bus.wr_en_i = 0;
    tot++; if (bus.count_o !== 16 || bus.overflow_o !== 1)
      $display("FAIL ovf_drop got count=%0d ovf=%b want 16 1", bus.count_o, bus.overflow_o); else pas++;
    tot++; if (bus.tx_data_o !== 8'h10) $display("FAIL ovf_inflight got %h want 10", bus.tx_data_o); else pas++;
  endtask

  task automatic test_pop_full;
    bus.flush_i = 1;
    @(negedge clk);
    bus.flush_i = 0;
    tot++; if (bus.count_o !== 0 || bus.empty_o !== 1 || bus.overflow_o !== 0)
      $display("FAIL flush_clear got count=%0d empty=%b ovf=%b want 0 1 0", bus.count_o, bus.empty_o, bus.overflow_o); else pas++;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en_i = 1; bus.wr_data_i = 8'h20 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en_i = 0;
    tot++; if (bus.count_o !== 16 || bus.full_o !== 1 || bus.overflow_o !== 0)
      $display("FAIL popfull_fill got count=%0d full=%b ovf=%b want 16 1 0", bus.count_o, bus.full_o, bus.overflow_o); else pas++;
    man_complete = 1;
    @(negedge clk);
    man_complete = 0;
    bus.wr_en_i = 1; bus.wr_data_i = 8'hEE;
    @(negedge clk);
    bus.wr_en_i = 0;
    tot++; if (bus.count_o !== 15 || bus.overflow_o !== 1 || bus.full_o !== 0)
      $display("FAIL popfull_drop got count=%0d ovf=%b full=%b want 15 1 0", bus.count_o, bus.overflow_o, bus.full_o); else pas++;
    tot++; if (bus.tx_start_o !== 1 || bus.tx_data_o !== 8'h20)
      $display("FAIL popfull_issue got start=%b data=%h want 1 20", bus.tx_start_o, bus.tx_data_o); else pas++;
  endtask

  task automatic test_flush;
    int n0;
    rst_n = 0; man_active = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en_i = 1; bus.wr_data_i = 8'h30 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en_i = 0; man_active = 1;
    @(negedge clk);
    tot++; if (bus.count_o !== 5 || bus.tx_data_o !== 8'h30)
      $display("FAIL flush_setup got count=%0d data=%h want 5 30", bus.count_o, bus.tx_data_o); else pas++;
    bus.flush_i = 1; bus.wr_en_i = 1; bus.wr_data_i = 8'h77;
    @(negedge clk);
    bus.flush_i = 0; bus.wr_en_i = 0;
    tot++; if (bus.count_o !== 0 || bus.empty_o !== 1 || bus.busy_o !== 1)
      $display("FAIL flush_wins got count=%0d empty=%b busy=%b want 0 1 1", bus.count_o, bus.empty_o, bus.busy_o); else pas++;
    n0 = n_start;
    man_active = 0; man_complete = 1;
    @(negedge clk);
    man_complete = 0;
    repeat (6) @(negedge clk);
    tot++; if (n_start != n0 || bus.busy_o !== 0)
      $display("FAIL flush_drain got extra_starts=%0d busy=%b want 0 0", n_start - n0, bus.busy_o); else pas++;
  endtask

  task automatic test_async_reset;
    int n0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_en_i = 1; bus.wr_data_i = 8'h41 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en_i = 0;
    repeat (2) @(negedge clk);
    man_active = 1;
    repeat (2) @(negedge clk);
    tot++; if (bus.count_o !== 1 || bus.busy_o !== 1)
      $display("FAIL areset_setup got count=%0d busy=%b want 1 1", bus.count_o, bus.busy_o); else pas++;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    tot++; if (bus.count_o !== 0 || bus.empty_o !== 1 || bus.busy_o !== 0)
      $display("FAIL areset_status got count=%0d empty=%b busy=%b want 0 1 0", bus.count_o, bus.empty_o, bus.busy_o); else pas++;
    tot++; if (bus.tx_start_o !== 0 || bus.tx_data_o !== 0)
      $display("FAIL areset_tx got start=%b data=%h want 0 00", bus.tx_start_o, bus.tx_data_o); else pas++;
    @(negedge clk);
    rst_n = 1; man_active = 0;
    n0 = n_start;
    repeat (6) @(negedge clk);
    tot++; if (n_start != n0 || bus.busy_o !== 0)
      $display("FAIL areset_stale got starts=%0d busy=%b want 0 0", n_start - n0, bus.busy_o); else pas++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_pop_full;
    test_flush;
    test_async_reset;
    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end
endmodule
